// File: rtl/dpll_nco_pd.sv
// NCO with an integrated sampling phase detector. It turns the loop filter's
// control word into a clamped frequency word and samples the phase on rising edges of REF_IN.
module dpll_nco_pd #(
  parameter int unsigned      ACC_W      = 16,
  parameter logic [ACC_W-1:0] CENTER     = 16'h1000,
  parameter int unsigned      GAIN_SHIFT = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [11:0]      D,
  input  logic             D_LD,
  input  logic             REF_IN,
  output logic [ACC_W-1:0] PHASE,
  output logic             NCO_OUT,
  output logic             TICK,
  output logic [7:0]       C,
  output logic             C_VLD,
  output logic             SAT
);

  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic [ACC_W-1:0] FWORD_MIN = ACC_W'(1);
  localparam logic [ACC_W-1:0] FWORD_MAX = {ACC_W{1'b1}};

  // Returns {saturated, fword}. The top bit of the sum is the sign, and bit ACC_W flags overflow.
  function automatic logic [ACC_W:0] clamp_fword(input logic signed [SUM_W-1:0] sum);
    logic [ACC_W:0] res;
    if (sum[SUM_W-1] || (sum == {SUM_W{1'b0}})) begin
      res = {1'b1, FWORD_MIN};
    end else if (sum[ACC_W]) begin
      res = {1'b1, FWORD_MAX};
    end else begin
      res = {1'b0, sum[ACC_W-1:0]};
    end
    return res;
  endfunction

  logic [ACC_W-1:0]        phase_q, phase_d;
  logic [ACC_W-1:0]        fword_q, fword_d;
  logic                    sat_q, sat_d;
  logic                    tick_q, tick_d;
  logic [7:0]              c_q, c_d;
  logic                    c_vld_q, c_vld_d;
  logic                    s1_q, s1_d;
  logic                    s2_q, s2_d;
  logic                    s3_q, s3_d;
  logic signed [SUM_W-1:0] d_ext_s;
  logic signed [SUM_W-1:0] center_ext_s;
  logic signed [SUM_W-1:0] sum_s;
  logic                    carry_s;
  logic                    ref_rise_s;

  assign d_ext_s      = SUM_W'(signed'(D));
  assign center_ext_s = signed'({2'b00, CENTER});
  assign ref_rise_s   = s2_q & ~s3_q;

  // Next-state logic for the accumulator, frequency word, phase detector and synchronizer.
  always_comb begin
    sum_s              = center_ext_s + (d_ext_s <<< GAIN_SHIFT);
    {carry_s, phase_d} = {1'b0, phase_q} + {1'b0, fword_q};
    tick_d             = carry_s;
    fword_d            = fword_q;
    sat_d              = sat_q;
    c_d                = c_q;
    c_vld_d            = 1'b0;
    s1_d               = REF_IN;
    s2_d               = s1_q;
    s3_d               = s2_q;
    if (D_LD) begin
      {sat_d, fword_d} = clamp_fword(sum_s);
    end else begin
      fword_d = fword_q;
      sat_d   = sat_q;
    end
    if (ref_rise_s) begin
      c_d     = phase_q[ACC_W-1 -: 8];
      c_vld_d = 1'b1;
    end else begin
      c_d     = c_q;
      c_vld_d = 1'b0;
    end
  end

  // State registers. Reset also discards any reference edge still in the synchronizer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase_q <= {ACC_W{1'b0}};
      fword_q <= CENTER;
      sat_q   <= 1'b0;
      tick_q  <= 1'b0;
      c_q     <= 8'h00;
      c_vld_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      fword_q <= fword_d;
      sat_q   <= sat_d;
      tick_q  <= tick_d;
      c_q     <= c_d;
      c_vld_q <= c_vld_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
    end
  end

  assign PHASE   = phase_q;
  assign NCO_OUT = phase_q[ACC_W-1];
  assign TICK    = tick_q;
  assign C       = c_q;
  assign C_VLD   = c_vld_q;
  assign SAT     = sat_q;

endmodule

// File: tb/tb_dpll_nco_pd.sv
// Self-checking bench for dpll_nco_pd. Three configurations share the same stimulus.
// A cycle-level arithmetic model produces the expected values.
module tb_dpll_nco_pd;

  localparam int NDUT = 3;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [11:0]     D;
  logic            D_LD;
  logic            REF_IN;
  logic [15:0]     phase_o [NDUT];
  logic [NDUT-1:0] nco_o;
  logic [NDUT-1:0] tick_o;
  logic [7:0]      c_o [NDUT];
  logic [NDUT-1:0] c_vld_o;
  logic [NDUT-1:0] sat_o;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dpll_nco_pd #(.ACC_W(16), .CENTER(16'h1000), .GAIN_SHIFT(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .D(D), .D_LD(D_LD), .REF_IN(REF_IN),
    .PHASE(phase_o[0]), .NCO_OUT(nco_o[0]), .TICK(tick_o[0]),
    .C(c_o[0]), .C_VLD(c_vld_o[0]), .SAT(sat_o[0]));

  dpll_nco_pd #(.ACC_W(16), .CENTER(16'hF000), .GAIN_SHIFT(4)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .D(D), .D_LD(D_LD), .REF_IN(REF_IN),
    .PHASE(phase_o[1]), .NCO_OUT(nco_o[1]), .TICK(tick_o[1]),
    .C(c_o[1]), .C_VLD(c_vld_o[1]), .SAT(sat_o[1]));

  dpll_nco_pd #(.ACC_W(16), .CENTER(16'h1000), .GAIN_SHIFT(4)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .D(D), .D_LD(D_LD), .REF_IN(REF_IN),
    .PHASE(phase_o[2]), .NCO_OUT(nco_o[2]), .TICK(tick_o[2]),
    .C(c_o[2]), .C_VLD(c_vld_o[2]), .SAT(sat_o[2]));

  // Reference model state, one entry per configuration.
  int m_center [NDUT] = '{4096, 61440, 4096};
  int m_gs     [NDUT] = '{0, 4, 4};
  int m_phase  [NDUT];
  int m_fword  [NDUT];
  int m_c      [NDUT];
  int m_tick   [NDUT];
  int m_cvld   [NDUT];
  int m_sat    [NDUT];
  bit ref_samp [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_phase[k] = 0;
      m_fword[k] = m_center[k];
      m_c[k]     = 0;
      m_tick[k]  = 0;
      m_cvld[k]  = 0;
      m_sat[k]   = 0;
    end
    ref_samp.delete();
  endtask

  // A REF_IN rise sampled at edge n-2 (with 0 sampled at n-3) is reported at edge n.
  task automatic model_edge();
    bit detect;
    int sum;
    int sd;
    int v;
    if (RESET) begin
      model_reset();
      return;
    end
    detect = (ref_samp.size() >= 2) && ref_samp[ref_samp.size()-2] &&
             ((ref_samp.size() < 3) || !ref_samp[ref_samp.size()-3]);
    ref_samp.push_back(REF_IN);
    sd = int'($signed(D));
    for (int k = 0; k < NDUT; k++) begin
      sum        = m_phase[k] + m_fword[k];
      m_tick[k]  = (sum >= 65536) ? 1 : 0;
      m_cvld[k]  = detect ? 1 : 0;
      if (detect) m_c[k] = m_phase[k] / 256;
      m_phase[k] = sum % 65536;
      if (D_LD) begin
        v = m_center[k] + sd * (1 << m_gs[k]);
        m_sat[k]   = (v < 1 || v > 65535) ? 1 : 0;
        m_fword[k] = (v < 1) ? 1 : ((v > 65535) ? 65535 : v);
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("phase%0d", k), 32'(phase_o[k]), m_phase[k]);
      check_eq($sformatf("nco%0d", k),   32'(nco_o[k]),   (m_phase[k] >= 32768) ? 1 : 0);
      check_eq($sformatf("tick%0d", k),  32'(tick_o[k]),  m_tick[k]);
      check_eq($sformatf("c%0d", k),     32'(c_o[k]),     m_c[k]);
      check_eq($sformatf("cvld%0d", k),  32'(c_vld_o[k]), m_cvld[k]);
      check_eq($sformatf("sat%0d", k),   32'(sat_o[k]),   m_sat[k]);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic load(input logic [11:0] dv);
    D    = dv;
    D_LD = 1'b1;
    step();
    D_LD = 1'b0;
  endtask

  initial begin
    int n;
    RESET  = 1'b1;
    D      = 12'h000;
    D_LD   = 1'b0;
    REF_IN = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    compare_all();
    RESET = 1'b0;

    // Free run from reset, then the first reference capture.
    repeat (3) step();
    check_eq("phase_after3", 32'(phase_o[0]), 32'h3000);
    REF_IN = 1'b1;
    repeat (3) step();
    check_eq("c_first", 32'(c_o[0]), 32'h50);
    check_eq("cvld_first", 32'(c_vld_o[0]), 32'h1);
    repeat (20) step();
    REF_IN = 1'b0;
    repeat (2) step();
    n = 0;
    while (m_phase[0] != 16'hD000 && n < 40) begin
      step();
      n++;
    end
    check_eq("align_bound", (n < 40) ? 32'h1 : 32'h0, 32'h1);
    REF_IN = 1'b1;
    repeat (3) step();
    check_eq("c_neg", 32'(c_o[0]), 32'hF0);
    REF_IN = 1'b0;
    repeat (4) step();

    // Frequency word loads and clamping.
    load(12'h100);
    check_eq("sat_0x100", 32'(sat_o[0]), 32'h0);
    repeat (3) step();
    load(12'h7FF);
    check_eq("sat0_7ff", 32'(sat_o[0]), 32'h0);
    check_eq("sat1_7ff", 32'(sat_o[1]), 32'h1);
    check_eq("sat2_7ff", 32'(sat_o[2]), 32'h0);
    repeat (3) step();
    load(12'h800);
    check_eq("sat1_m2048", 32'(sat_o[1]), 32'h0);
    check_eq("sat2_m2048", 32'(sat_o[2]), 32'h1);
    repeat (3) step();
    load(12'h000);
    check_eq("sat2_zero", 32'(sat_o[2]), 32'h0);
    repeat (3) step();

    // Reference detect coinciding with a load.
    REF_IN = 1'b1;
    repeat (2) step();
    load(12'h123);
    check_eq("cvld_coincide", 32'(c_vld_o[0]), 32'h1);
    REF_IN = 1'b0;
    repeat (3) step();

    // Asynchronous reset with an edge in the synchronizer and SAT set.
    load(12'h800);
    REF_IN = 1'b1;
    step();
    #2 RESET = 1'b1;
    #1 model_reset();
    compare_all();
    check_eq("sat2_async_rst", 32'(sat_o[2]), 32'h0);
    REF_IN = 1'b0;
    repeat (2) step();
    RESET = 1'b0;
    repeat (20) step();

    // Randomized run.
    for (int i = 0; i < 1500; i++) begin
      D     = 12'($urandom);
      D_LD  = ($urandom_range(0, 3) == 0);
      RESET = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) REF_IN = ~REF_IN;
      step();
    end
    RESET = 1'b0;
    D_LD  = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
